// File: rtl/lock_key_seq.sv
// Key-load and unlock sequencer: shifts in a serial key, checks it against KEY_REF,
// releases the locked core on a match and locks out after MAX_TRIES failed checks.
module lock_key_seq #(
    parameter int               KEY_W     = 8,
    parameter logic [KEY_W-1:0] KEY_REF   = 8'hA5,
    parameter int               MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             kin_valid,
    input  logic             kin_bit,
    output logic             kin_ready,
    output logic             core_rst,
    output logic [KEY_W-1:0] key_out,
    output logic             key_ok,
    output logic             fail_pulse,
    output logic [1:0]       fail_cnt,
    output logic             locked_out
);

    localparam int               CNT_W  = $clog2(KEY_W) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(KEY_W - 1);
    localparam logic [1:0]       C_MAX  = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_CHECK   = 3'd2,
        S_FAIL    = 3'd3,
        S_RUN     = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t           r_state, w_state_next;
    logic [KEY_W-1:0] r_shreg, w_shreg_next;
    logic [KEY_W-1:0] r_key_out, w_key_out_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [1:0]       r_fail_cnt, w_fail_cnt_next;

    // The locked core samples on the rising edge, so this block advances on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_key_out  <= '0;
            r_cnt      <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_shreg    <= w_shreg_next;
            r_key_out  <= w_key_out_next;
            r_cnt      <= w_cnt_next;
            r_fail_cnt <= w_fail_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shreg_next    = r_shreg;
        w_key_out_next  = r_key_out;
        w_cnt_next      = r_cnt;
        w_fail_cnt_next = r_fail_cnt;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_next = S_SHIFT;
                    w_shreg_next = '0;
                    w_cnt_next   = '0;
                end
            end
            S_SHIFT: begin
                if (kin_valid) begin
                    w_shreg_next = {r_shreg[KEY_W-2:0], kin_bit};
                    w_cnt_next   = r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (r_shreg == KEY_REF) begin
                    w_key_out_next  = r_shreg;
                    w_fail_cnt_next = '0;
                    w_state_next    = S_RUN;
                end else begin
                    if (r_fail_cnt != C_MAX) begin
                        w_fail_cnt_next = r_fail_cnt + 2'd1;
                    end
                    if (r_fail_cnt + 2'd1 == C_MAX) begin
                        w_state_next = S_LOCKOUT;
                    end else begin
                        w_state_next = S_FAIL;
                    end
                end
            end
            S_FAIL: begin
                w_state_next = S_IDLE;
            end
            S_RUN: begin
                // Re-key drops the key first so the core is reset before any new key lands.
                if (load_start) begin
                    w_state_next   = S_SHIFT;
                    w_key_out_next = '0;
                    w_shreg_next   = '0;
                    w_cnt_next     = '0;
                end
            end
            S_LOCKOUT: begin
                w_state_next = S_LOCKOUT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign kin_ready  = (r_state == S_SHIFT);
    assign core_rst   = (r_state != S_RUN);
    assign key_ok     = (r_state == S_RUN);
    assign fail_pulse = (r_state == S_FAIL);
    assign locked_out = (r_state == S_LOCKOUT);
    assign key_out    = r_key_out;
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_lock_key_seq.sv
// Directed bench for lock_key_seq: each key load pushes its predicted outcome to a
// scoreboard queue, which is popped and compared when the DUT reports the result.
module tb_lock_key_seq;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic       kin_valid;
    logic       kin_bit;
    logic       kin_ready;
    logic       core_rst;
    logic [7:0] key_out;
    logic       key_ok;
    logic       fail_pulse;
    logic [1:0] fail_cnt;
    logic       locked_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int m_fail = 0;

    typedef struct {
        logic [7:0] key;
        logic       key_ok;
        logic       fail_pulse;
        logic       locked_out;
        logic       core_rst;
        logic [7:0] key_out;
        logic [1:0] fail_cnt;
        int         lat;
    } exp_t;

    exp_t sb[$];

    lock_key_seq #(.KEY_W(8), .KEY_REF(8'hA5), .MAX_TRIES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .kin_valid  (kin_valid),
        .kin_bit    (kin_bit),
        .kin_ready  (kin_ready),
        .core_rst   (core_rst),
        .key_out    (key_out),
        .key_ok     (key_ok),
        .fail_pulse (fail_pulse),
        .fail_cnt   (fail_cnt),
        .locked_out (locked_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Falling edges are the DUT's active edges; counting them gives latency in DUT cycles.
    always @(negedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_rst"},   core_rst,   1);
        chk({tag, "_kin_ready"},  kin_ready,  0);
        chk({tag, "_key_ok"},     key_ok,     0);
        chk({tag, "_fail_pulse"}, fail_pulse, 0);
        chk({tag, "_locked_out"}, locked_out, 0);
        chk({tag, "_fail_cnt"},   fail_cnt,   0);
        chk({tag, "_key_out"},    key_out,    0);
    endtask

    // Called just after a rising edge with the DUT in IDLE or RUN.
    task automatic load_key(input logic [7:0] key, input int stall_after,
                            input int stall_len, input bit hold_start);
        exp_t e;
        exp_t x;
        int   t0;
        t0 = cyc;
        load_start = 1'b1;
        kin_valid  = 1'b0;
        @(posedge clk);
        chk("shift_ready", kin_ready, 1);
        chk("shift_core_rst", core_rst, 1);
        chk("shift_key_out", key_out, 0);
        load_start = hold_start;
        for (int i = 0; i < 8; i++) begin
            kin_valid = 1'b1;
            kin_bit   = key[7-i];
            @(posedge clk);
            if (i == stall_after - 1) begin
                kin_valid = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk);
                    chk("stall_ready", kin_ready, 1);
                end
            end
        end
        kin_valid  = 1'b0;
        load_start = 1'b0;
        chk("check_ready", kin_ready, 0);
        chk("check_core_rst", core_rst, 1);

        e.key = key;
        e.lat = 10 + stall_len;
        if (key == 8'hA5) begin
            m_fail = 0;
            e.key_ok = 1; e.fail_pulse = 0; e.locked_out = 0; e.core_rst = 0; e.key_out = 8'hA5;
        end else if (m_fail + 1 == 3) begin
            m_fail = 3;
            e.key_ok = 0; e.fail_pulse = 0; e.locked_out = 1; e.core_rst = 1; e.key_out = 8'h00;
        end else begin
            m_fail++;
            e.key_ok = 0; e.fail_pulse = 1; e.locked_out = 0; e.core_rst = 1; e.key_out = 8'h00;
        end
        e.fail_cnt = 2'(m_fail);
        sb.push_back(e);

        @(posedge clk);
        x = sb.pop_front();
        chk("res_key_ok",     key_ok,     x.key_ok);
        chk("res_fail_pulse", fail_pulse, x.fail_pulse);
        chk("res_locked_out", locked_out, x.locked_out);
        chk("res_core_rst",   core_rst,   x.core_rst);
        chk("res_key_out",    key_out,    x.key_out);
        chk("res_fail_cnt",   fail_cnt,   x.fail_cnt);
        chk("res_latency",    cyc - t0,   x.lat);
        $display("load key=%02h stall=%0d -> key_ok=%0b fail=%0b lock=%0b key_out=%02h fail_cnt=%0d lat=%0d",
                 key, stall_len, key_ok, fail_pulse, locked_out, key_out, fail_cnt, cyc - t0);
        if (x.fail_pulse) begin
            @(posedge clk);
            chk("post_fail_pulse", fail_pulse, 0);
            chk("post_fail_ready", kin_ready, 0);
            chk("post_fail_core_rst", core_rst, 1);
            chk("post_fail_cnt", fail_cnt, x.fail_cnt);
        end
    endtask

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        kin_valid  = 1'b0;
        kin_bit    = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_vals("init");
        repeat (2) @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        chk_reset_vals("idle");

        // Correct key, continuous valid
        load_key(8'hA5, 0, 0, 1'b0);

        // Correct key with a 3-cycle stall after bit 4, re-keyed from RUN
        load_key(8'hA5, 4, 3, 1'b0);

        // Three wrong keys lead to lockout
        load_key(8'hA4, 0, 0, 1'b0);
        load_key(8'hA4, 0, 0, 1'b0);
        load_key(8'hA4, 0, 0, 1'b0);
        load_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            kin_valid = 1'b1;
            kin_bit   = i[0];
            @(posedge clk);
            chk("lock_ready", kin_ready, 0);
            chk("lock_core_rst", core_rst, 1);
            chk("lock_flag", locked_out, 1);
            chk("lock_cnt", fail_cnt, 3);
        end
        load_start = 1'b0;
        kin_valid  = 1'b0;
        #2 rst = 1'b1;
        m_fail = 0;
        #1 chk_reset_vals("rst_lockout");
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);

        // One wrong key, then the right one clears the fail count
        load_key(8'h5A, 0, 0, 1'b0);
        load_key(8'hA5, 0, 0, 1'b0);
        load_start = 1'b1;
        @(posedge clk);
        load_start = 1'b0;
        chk("rekey_core_rst", core_rst, 1);
        chk("rekey_key_out", key_out, 0);
        chk("rekey_ready", kin_ready, 1);
        chk("rekey_key_ok", key_ok, 0);

        // Asynchronous reset mid-shift after 5 bits
        for (int i = 0; i < 5; i++) begin
            kin_valid = 1'b1;
            kin_bit   = 1'b1;
            @(posedge clk);
        end
        kin_valid = 1'b0;
        #2 rst = 1'b1;
        m_fail = 0;
        #1 chk_reset_vals("rst_shift");
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        load_key(8'hA5, 0, 0, 1'b0);

        // load_start held through SHIFT must not restart the sequence
        load_key(8'hA5, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
